// File: rtl/arbiter_pkg.sv
// Shared types and constants for the weighted round-robin arbiter family.
package arbiter_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } arb_state_e;

  // Credit loaded when a winner's programmed weight is zero.
  localparam int unsigned WEIGHT_ZERO_LOAD = 1;

endpackage

// File: rtl/rr_pick.sv
// Combinational masked round-robin picker: first set req bit at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         onehot_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 found_o
);

  localparam int unsigned IDW = $clog2(N);

  int unsigned         k;
  logic [IDW-1:0]      kk;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found_o  = 1'b0;
    k        = 0;
    kk       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k = int'(ptr_i) + i;
      if (k >= N) k = k - N;
      kk = IDW'(k);
      if (!found_o && req_i[kk]) begin
        found_o      = 1'b1;
        onehot_o[kk] = 1'b1;
        idx_o        = kk;
      end
    end
  end

endmodule

// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter with per-client credit; define ARBITER_WRR_LOCK_EN
// to add lock_i, which holds the current grant against ack-driven release.
module arbiter_wrr
  import arbiter_pkg::*;
#(
  parameter int unsigned CLIENTS  = 4,
  parameter int unsigned WEIGHT_W = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CLIENTS-1:0]           req_i,
  input  logic [CLIENTS*WEIGHT_W-1:0]  weight_i,
  input  logic                         ack_i,
`ifdef ARBITER_WRR_LOCK_EN
  input  logic                         lock_i,
`endif
  output logic [CLIENTS-1:0]           gnt_o,
  output logic [$clog2(CLIENTS)-1:0]   gnt_id_o,
  output logic                         gnt_valid_o
);

  localparam int unsigned IDW = $clog2(CLIENTS);

  arb_state_e           state_q, state_d;
  logic [CLIENTS-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0]       id_q, id_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [WEIGHT_W-1:0]  credit_q, credit_d;

  logic                 lock;
  logic                 release_now;
  logic [IDW-1:0]       next_ptr;
  logic [IDW-1:0]       pick_ptr;
  logic [CLIENTS-1:0]   pick_onehot;
  logic [IDW-1:0]       pick_idx;
  logic                 pick_found;
  logic [WEIGHT_W-1:0]  win_weight;
  logic [WEIGHT_W-1:0]  win_credit;

`ifdef ARBITER_WRR_LOCK_EN
  assign lock = lock_i;
`else
  assign lock = 1'b0;
`endif

  assign next_ptr = (id_q == IDW'(CLIENTS - 1)) ? '0 : id_q + IDW'(1);

  // Release decision is kept apart from next-state logic so the picker's
  // pointer never depends on the picker's own outputs.
  always_comb begin
    release_now = 1'b0;
    if (state_q == ST_GRANT) begin
      if (!(|(req_i & gnt_q))) begin
        release_now = 1'b1;
      end else if (ack_i && !lock && (credit_q == WEIGHT_W'(1))) begin
        release_now = 1'b1;
      end
    end
    pick_ptr = release_now ? next_ptr : ptr_q;
  end

  rr_pick #(.N(CLIENTS)) u_rr_pick (
    .req_i    (req_i),
    .ptr_i    (pick_ptr),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .found_o  (pick_found)
  );

  assign win_weight = weight_i[int'(pick_idx)*WEIGHT_W +: WEIGHT_W];
  assign win_credit = (win_weight == '0) ? WEIGHT_W'(WEIGHT_ZERO_LOAD) : win_weight;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    id_d     = id_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;

    if (state_q == ST_GRANT && !release_now && ack_i && !lock) begin
      credit_d = credit_q - WEIGHT_W'(1);
    end

    if (state_q == ST_IDLE || release_now) begin
      ptr_d = pick_ptr;
      if (pick_found) begin
        state_d  = ST_GRANT;
        gnt_d    = pick_onehot;
        id_d     = pick_idx;
        credit_d = win_credit;
      end else begin
        state_d  = ST_IDLE;
        gnt_d    = '0;
        id_d     = '0;
        credit_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      id_q     <= '0;
      ptr_q    <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_id_o    = id_q;
  assign gnt_valid_o = (state_q == ST_GRANT);

endmodule

// File: tb/tb_arbiter_wrr.sv
// Self-checking bench for arbiter_wrr against a behavioural grant/credit model.
module tb_arbiter_wrr;

  localparam int C  = 4;
  localparam int W  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [C-1:0]   req;
  logic [C*W-1:0] weight;
  logic           ack;
  logic           lock;
  logic [C-1:0]   gnt_o;
  logic [IW-1:0]  gnt_id_o;
  logic           gnt_valid_o;

  int checks   = 0;
  int failures = 0;

  // Model: current owner (-1 none), remaining credit, round-robin pointer.
  int m_gnt;
  int m_credit;
  int m_ptr;

  always #5 clk = ~clk;

  arbiter_wrr #(.CLIENTS(C), .WEIGHT_W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .weight_i    (weight),
    .ack_i       (ack),
`ifdef ARBITER_WRR_LOCK_EN
    .lock_i      (lock),
`endif
    .gnt_o       (gnt_o),
    .gnt_id_o    (gnt_id_o),
    .gnt_valid_o (gnt_valid_o)
  );

  function automatic int pick(input logic [C-1:0] r, input int p);
    for (int i = 0; i < C; i++) begin
      int k;
      k = (p + i) % C;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  function automatic int wload(input int k);
    int w;
    w = int'(weight[k*W +: W]);
    return (w == 0) ? 1 : w;
  endfunction

  task automatic model_reset();
    m_gnt = -1; m_credit = 0; m_ptr = 0;
  endtask

  task automatic model_step();
    int lk;
    bit rel;
    int w;
    lk = 0;
`ifdef ARBITER_WRR_LOCK_EN
    lk = int'(lock);
`endif
    rel = 0;
    if (m_gnt < 0) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin m_gnt = w; m_credit = wload(w); end
    end else begin
      if (!req[m_gnt]) rel = 1;
      else if (ack && lk == 0) begin
        if (m_credit == 1) rel = 1;
        else m_credit = m_credit - 1;
      end
      if (rel) begin
        m_ptr = (m_gnt + 1) % C;
        w = pick(req, m_ptr);
        if (w >= 0) begin m_gnt = w; m_credit = wload(w); end
        else begin m_gnt = -1; m_credit = 0; end
      end
    end
  endtask

  // One clock: model advances on current inputs, DUT sampled 1ns after the edge.
  task automatic step_check(input string tag);
    logic [C-1:0]  eg;
    logic [IW-1:0] ei;
    logic          ev;
    model_step();
    @(posedge clk);
    #1;
    eg = (m_gnt < 0) ? '0 : (C'(1) << m_gnt);
    ei = (m_gnt < 0) ? '0 : IW'(m_gnt);
    ev = (m_gnt >= 0);
    checks++;
    if ({gnt_o, gnt_id_o, gnt_valid_o} !== {eg, ei, ev}) begin
      failures++;
      $display("FAIL %s model: gnt=%b id=%0d valid=%b expected gnt=%b id=%0d valid=%b at %0t",
               tag, gnt_o, gnt_id_o, gnt_valid_o, eg, ei, ev, $time);
    end
    checks++;
    if ($countones(gnt_o) > 1) begin
      failures++;
      $display("FAIL %s onehot: gnt=%b expected at most one bit", tag, gnt_o);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; ack = 1'b0; lock = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({gnt_o, gnt_id_o, gnt_valid_o} !== '0) begin
      failures++;
      $display("FAIL reset_state: gnt=%b id=%0d valid=%b expected all zero",
               gnt_o, gnt_id_o, gnt_valid_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    weight = {C{4'd1}};
    req = 4'b0000; ack = 1'b1;
    step_check("idle_ack_ignored");
  endtask

  task automatic test_rr_equal();
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    do_reset();
    weight = {C{4'd1}};
    req = 4'b1111; ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step_check("rr_equal");
      checks++;
      if (gnt_id_o !== IW'(exp_seq[i]) || gnt_valid_o !== 1'b1) begin
        failures++;
        $display("FAIL rr_equal_seq[%0d]: id=%0d valid=%b expected id=%0d valid=1",
                 i, gnt_id_o, gnt_valid_o, exp_seq[i]);
      end
    end
  endtask

  task automatic test_weighted();
    int exp_seq[7] = '{0, 0, 0, 1, 2, 3, 3};
    do_reset();
    weight = {4'd2, 4'd1, 4'd1, 4'd3};
    req = 4'b1111; ack = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step_check("weighted");
      checks++;
      if (gnt_id_o !== IW'(exp_seq[i % 7])) begin
        failures++;
        $display("FAIL weighted_seq[%0d]: id=%0d expected %0d", i, gnt_id_o, exp_seq[i % 7]);
      end
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    weight = {4'd1, 4'd4, 4'd1, 4'd1};
    req = 4'b0100; ack = 1'b0;
    step_check("withdraw_grant");
    req = 4'b1100; ack = 1'b1;
    step_check("withdraw_ack");
    checks++;
    if (gnt_id_o !== IW'(2)) begin
      failures++;
      $display("FAIL withdraw_hold: id=%0d expected 2", gnt_id_o);
    end
    req = 4'b1000; ack = 1'b0;
    step_check("withdraw_release");
    checks++;
    if (gnt_id_o !== IW'(3) || gnt_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL withdraw_next: id=%0d valid=%b expected id=3 valid=1", gnt_id_o, gnt_valid_o);
    end
  endtask

  task automatic test_regrant();
    do_reset();
    weight = {4'd1, 4'd1, 4'd2, 4'd1};
    req = 4'b0010; ack = 1'b0;
    step_check("regrant_start");
    ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step_check("regrant");
      checks++;
      if (gnt_id_o !== IW'(1) || gnt_valid_o !== 1'b1) begin
        failures++;
        $display("FAIL regrant[%0d]: id=%0d valid=%b expected id=1 valid=1", i, gnt_id_o, gnt_valid_o);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    weight = {C{4'd2}};
    req = 4'b1111; ack = 1'b0;
    step_check("areset_pre");
    step_check("areset_pre");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({gnt_o, gnt_id_o, gnt_valid_o} !== '0) begin
      failures++;
      $display("FAIL async_reset_drop: gnt=%b id=%0d valid=%b expected all zero",
               gnt_o, gnt_id_o, gnt_valid_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1010;
    step_check("areset_first");
    checks++;
    if (gnt_id_o !== IW'(1) || gnt_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL async_reset_first: id=%0d valid=%b expected id=1 valid=1", gnt_id_o, gnt_valid_o);
    end
  endtask

`ifdef ARBITER_WRR_LOCK_EN
  task automatic test_lock();
    do_reset();
    weight = {C{4'd1}};
    req = 4'b0011; ack = 1'b0; lock = 1'b1;
    step_check("lock_start");
    ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step_check("lock_hold");
      checks++;
      if (gnt_id_o !== IW'(0) || gnt_valid_o !== 1'b1) begin
        failures++;
        $display("FAIL lock_hold[%0d]: id=%0d valid=%b expected id=0 valid=1", i, gnt_id_o, gnt_valid_o);
      end
    end
    lock = 1'b0;
    step_check("lock_release");
    checks++;
    if (gnt_id_o !== IW'(1)) begin
      failures++;
      $display("FAIL lock_release: id=%0d expected 1", gnt_id_o);
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    weight = $urandom;
    for (int i = 0; i < 400; i++) begin
      req  = C'($urandom) | C'($urandom);
      ack  = ($urandom_range(0, 3) != 0);
      lock = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 15) == 0) weight = $urandom;
      step_check("random");
    end
  endtask

  initial begin
    test_reset();
    test_rr_equal();
    test_weighted();
    test_withdraw();
    test_regrant();
    test_async_reset();
`ifdef ARBITER_WRR_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
